rtermcal_ctrl: RTL and testbench

Digital successive-approximation controller for the EG1d80V on-die termination calibration cell. It drives the cell's SGIO thermometer trim and LVDS binary trim, and samples the cell's asynchronous comparator outputs with a synchronizer and majority filter. It binary-searches the largest trim code whose trim resistance is still at or above the external reference, then holds that code on the trim buses for the functional IOs. It sits in the IO-ring control domain between the chip configuration registers and the calibration cell.

---
 rtl/rtermcal_pkg.sv | 29 ++
 rtl/rtermcal_therm_dec.sv | 22 ++
 rtl/rtermcal_ctrl.sv | 250 +++++++++++++++++++++++++
 tb/tb_rtermcal_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rtermcal_pkg.sv
// Purpose: shared types and encodings for the ODT calibration controller.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package rtermcal_pkg;

  // Search sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DECIDE = 3'd4,
    ST_FINISH = 3'd5
  } state_e;

  // Calibration select encodings, also driven onto the cell MODE_I pins.
  localparam logic [1:0] MODE_IDLE = 2'b00;
  localparam logic [1:0] MODE_SG   = 2'b01;
  localparam logic [1:0] MODE_LVDS = 2'b10;

  // err_o bit positions.
  localparam int ERR_MODE = 0;  // illegal calibration select
  localparam int ERR_SAT  = 1;  // final code pinned at 0 or all-ones

  function automatic logic mode_legal(input logic [1:0] m);
    return (m == MODE_SG) || (m == MODE_LVDS);
  endfunction

endpackage

// File: rtl/rtermcal_therm_dec.sv
// Purpose: binary code to thermometer trim decoder for the SGIO leg array.
// Latency: combinational; the parent registers the result.
// Backpressure: none.
//
// Ports:
//   code_i  - binary code, 0 .. 2^BITS-1
//   therm_o - therm_o[i-1] is 1 exactly when i <= code_i, for i = 1 .. 2^BITS-1
module rtermcal_therm_dec #(
  parameter int BITS = 4
) (
  input  logic [BITS-1:0]     code_i,
  output logic [(2**BITS)-2:0] therm_o
);

  always_comb begin
    therm_o = '0;
    for (int i = 1; i < 2**BITS; i++) begin
      therm_o[i-1] = (i <= int'(code_i));
    end
  end

endmodule

// File: rtl/rtermcal_ctrl.sv
// Purpose: successive-approximation controller for the on-die termination calibration cell.
// Latency: start to done_o = 1 + W*(SETTLE_CYC+N_SAMPLE+2) cycles; illegal mode reports in 1 cycle.
// Backpressure: none; start_i is ignored while a search runs, abort_i cancels it.
//
// Ports:
//   clk_i, rst_ni       - block clock, asynchronous active-low reset
//   start_i, mode_i     - start request and calibration select (01 SGIO, 10 LVDS)
//   abort_i             - cancel a running search
//   result_i            - asynchronous comparator outputs from the cell
//   cal_mode_o          - cell MODE_I, 00 outside a search
//   d_iosg_o, d_lvds_o  - trim buses to the cell / functional IOs
//   code_sg_o, code_lvds_o - stored calibration codes
//   busy_o, done_o, err_o  - status; err_o is sticky until the next accepted start
module rtermcal_ctrl
  import rtermcal_pkg::*;
#(
  parameter int SG_BITS    = 4,
  parameter int LVDS_BITS  = 4,
  parameter int SETTLE_CYC = 16,  // >= 3 so the result synchronizer has flushed
  parameter int N_SAMPLE   = 3    // odd so the majority vote cannot tie
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic [1:0]              mode_i,
  input  logic                    abort_i,
  input  logic [1:0]              result_i,
  output logic [1:0]              cal_mode_o,
  output logic [(2**SG_BITS)-2:0] d_iosg_o,
  output logic [LVDS_BITS-1:0]    d_lvds_o,
  output logic [SG_BITS-1:0]      code_sg_o,
  output logic [LVDS_BITS-1:0]    code_lvds_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [1:0]              err_o
);

  localparam int THERM_W = (2**SG_BITS) - 1;
  localparam int TW      = (SG_BITS > LVDS_BITS) ? SG_BITS : LVDS_BITS;
  localparam int PW      = (TW > 1) ? $clog2(TW) : 1;
  localparam int CMAX    = (SETTLE_CYC > N_SAMPLE) ? SETTLE_CYC : N_SAMPLE;
  localparam int CW      = $clog2(CMAX);
  localparam int OW      = $clog2(N_SAMPLE + 1);

  localparam logic [SG_BITS-1:0]   SG_MID       = SG_BITS'(1) << (SG_BITS - 1);
  localparam logic [LVDS_BITS-1:0] LVDS_MID     = LVDS_BITS'(1) << (LVDS_BITS - 1);
  localparam logic [THERM_W-1:0]   SG_MID_THERM = THERM_W'((64'd1 << (2**(SG_BITS-1))) - 64'd1);

  // Registers
  state_e                 state_q, state_d;
  logic [1:0]             mode_q, mode_d;
  logic [TW-1:0]          trial_q, trial_d;
  logic [PW-1:0]          ptr_q, ptr_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [OW-1:0]          ones_q, ones_d;
  logic [SG_BITS-1:0]     code_sg_q, code_sg_d;
  logic [LVDS_BITS-1:0]   code_lvds_q, code_lvds_d;
  logic [1:0]             err_q, err_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [1:0]             cal_mode_q, cal_mode_d;
  logic [THERM_W-1:0]     d_iosg_q;
  logic [LVDS_BITS-1:0]   d_lvds_q, d_lvds_d;
  logic [1:0]             sync1_q, sync2_q;

  // Comb helpers
  logic                   samp_bit;
  logic [TW-1:0]          dec_code;
  logic                   searching_d;
  logic [SG_BITS-1:0]     sg_show_d;
  logic [THERM_W-1:0]     d_iosg_d;

  // Comparator bit of the channel under calibration, after the 2-flop synchronizer.
  assign samp_bit = (mode_q == MODE_SG) ? sync2_q[0] : sync2_q[1];

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    trial_d     = trial_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    ones_d      = ones_q;
    code_sg_d   = code_sg_q;
    code_lvds_d = code_lvds_q;
    err_d       = err_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    cal_mode_d  = cal_mode_q;
    dec_code    = trial_q;

    if (abort_i && (state_q != ST_IDLE)) begin
      // Abort wins over any progress; stored codes and err are left alone.
      state_d    = ST_IDLE;
      busy_d     = 1'b0;
      cal_mode_d = MODE_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            err_d = '0;
            if (mode_legal(mode_i)) begin
              mode_d     = mode_i;
              ptr_d      = (mode_i == MODE_SG) ? PW'(SG_BITS - 1) : PW'(LVDS_BITS - 1);
              // The MSB trial bit is raised on entry so the cell sees it from the first SETUP cycle.
              trial_d    = TW'(1) << ptr_d;
              cal_mode_d = mode_i;
              busy_d     = 1'b1;
              state_d    = ST_SETUP;
            end else begin
              err_d[ERR_MODE] = 1'b1;
              done_d          = 1'b1;
              state_d         = ST_FINISH;
            end
          end
        end

        ST_SETUP: begin
          cnt_d   = '0;
          state_d = ST_SETTLE;
        end

        ST_SETTLE: begin
          if (cnt_q == CW'(SETTLE_CYC - 1)) begin
            cnt_d   = '0;
            ones_d  = '0;
            state_d = ST_SAMPLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        ST_SAMPLE: begin
          ones_d = ones_q + OW'(samp_bit);
          if (cnt_q == CW'(N_SAMPLE - 1)) begin
            state_d = ST_DECIDE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        ST_DECIDE: begin
          // Majority of "trim too low" votes drops the bit under test.
          if (ones_q > OW'(N_SAMPLE / 2)) begin
            dec_code[ptr_q] = 1'b0;
          end
          if (ptr_q == '0) begin
            // Commit here so code and err are already valid while done_o is high.
            trial_d = dec_code;
            if (mode_q == MODE_SG) begin
              code_sg_d      = dec_code[SG_BITS-1:0];
              err_d[ERR_SAT] = (dec_code[SG_BITS-1:0] == '0) || (dec_code[SG_BITS-1:0] == '1);
            end else begin
              code_lvds_d    = dec_code[LVDS_BITS-1:0];
              err_d[ERR_SAT] = (dec_code[LVDS_BITS-1:0] == '0) || (dec_code[LVDS_BITS-1:0] == '1);
            end
            busy_d     = 1'b0;
            done_d     = 1'b1;
            cal_mode_d = MODE_IDLE;
            state_d    = ST_FINISH;
          end else begin
            ptr_d            = ptr_q - 1'b1;
            trial_d          = dec_code;
            trial_d[ptr_d]   = 1'b1;
            state_d          = ST_SETUP;
          end
        end

        ST_FINISH: begin
          state_d = ST_IDLE;
        end

        default: begin
          state_d    = ST_IDLE;
          busy_d     = 1'b0;
          cal_mode_d = MODE_IDLE;
        end
      endcase
    end
  end

  // Trim buses follow the trial register only while a search is in flight on that channel.
  assign searching_d = (state_d == ST_SETUP) || (state_d == ST_SETTLE) ||
                       (state_d == ST_SAMPLE) || (state_d == ST_DECIDE);

  always_comb begin
    sg_show_d = code_sg_d;
    d_lvds_d  = code_lvds_d;
    if (searching_d && (mode_d == MODE_SG)) begin
      sg_show_d = trial_d[SG_BITS-1:0];
    end
    if (searching_d && (mode_d == MODE_LVDS)) begin
      d_lvds_d = trial_d[LVDS_BITS-1:0];
    end
  end

  rtermcal_therm_dec #(
    .BITS (SG_BITS)
  ) u_therm_dec (
    .code_i  (sg_show_d),
    .therm_o (d_iosg_d)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_IDLE;
      trial_q     <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      ones_q      <= '0;
      code_sg_q   <= SG_MID;
      code_lvds_q <= LVDS_MID;
      err_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cal_mode_q  <= MODE_IDLE;
      d_iosg_q    <= SG_MID_THERM;
      d_lvds_q    <= LVDS_MID;
      sync1_q     <= '0;
      sync2_q     <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      trial_q     <= trial_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      ones_q      <= ones_d;
      code_sg_q   <= code_sg_d;
      code_lvds_q <= code_lvds_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cal_mode_q  <= cal_mode_d;
      d_iosg_q    <= d_iosg_d;
      d_lvds_q    <= d_lvds_d;
      sync1_q     <= result_i;
      sync2_q     <= sync1_q;
    end
  end

  assign cal_mode_o  = cal_mode_q;
  assign d_iosg_o    = d_iosg_q;
  assign d_lvds_o    = d_lvds_q;
  assign code_sg_o   = code_sg_q;
  assign code_lvds_o = code_lvds_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_rtermcal_ctrl.sv
// Purpose: self-checking bench for rtermcal_ctrl against a behavioural cell and search-result model.
// Latency: checks done_o timing of 1 + W*(SETTLE+N+2) cycles from the accepted start.
// Backpressure: exercises abort, start-while-busy and asynchronous reset mid-search.
module tb_rtermcal_ctrl;
  import rtermcal_pkg::*;

  localparam int SGB  = 4;
  localparam int LVB  = 4;
  localparam int SET  = 16;
  localparam int NS   = 3;
  localparam int TH_W = (2**SGB) - 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            start = 1'b0;
  logic [1:0]      mode = 2'b00;
  logic            abort = 1'b0;
  logic [1:0]      result = 2'b00;
  logic [1:0]      cal_mode;
  logic [TH_W-1:0] d_iosg;
  logic [LVB-1:0]  d_lvds;
  logic [SGB-1:0]  code_sg;
  logic [LVB-1:0]  code_lv;
  logic            busy, done;
  logic [1:0]      err;

  rtermcal_ctrl #(
    .SG_BITS(SGB), .LVDS_BITS(LVB), .SETTLE_CYC(SET), .N_SAMPLE(NS)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .mode_i(mode), .abort_i(abort),
    .result_i(result), .cal_mode_o(cal_mode), .d_iosg_o(d_iosg), .d_lvds_o(d_lvds),
    .code_sg_o(code_sg), .code_lvds_o(code_lv), .busy_o(busy), .done_o(done), .err_o(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Cell behaviour: 0 = real cell (too low when code > target), 1 = stuck 11,
  // 2 = stuck 00, 3 = single-cycle glitch high once every 3 cycles.
  int cell_kind = 0;
  int tgt_sg = 0;
  int tgt_lv = 0;
  int cyc = 0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    case (cell_kind)
      0: result = {(int'(d_lvds) > tgt_lv), ($countones(d_iosg) > tgt_sg)};
      1: result = 2'b11;
      2: result = 2'b00;
      default: result = ((cyc % 3) == 0) ? 2'b11 : 2'b00;
    endcase
  end

  // Reference: the search lands on the largest code the cell does not call "too low".
  function automatic logic cell_too_low(input int kind, input int c, input int tgt);
    case (kind)
      0: return c > tgt;
      1: return 1'b1;
      default: return 1'b0;  // stuck-low, or a glitch outvoted by the majority
    endcase
  endfunction

  function automatic int ref_code(input int kind, input int tgt, input int width);
    int best = 0;
    for (int c = 0; c < (1 << width); c++) begin
      if (!cell_too_low(kind, c, tgt)) best = c;
    end
    return best;
  endfunction

  function automatic logic [31:0] therm_of(input int c);
    return (32'd1 << c) - 32'd1;
  endfunction

  // Model of the stored state
  int exp_sg = 8;
  int exp_lv = 8;
  logic [1:0] exp_err = 2'b00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic check_stored(input string tag);
    check({tag, "/code_sg"}, 32'(code_sg), 32'(exp_sg));
    check({tag, "/code_lv"}, 32'(code_lv), 32'(exp_lv));
    check({tag, "/d_iosg"}, 32'(d_iosg), therm_of(exp_sg));
    check({tag, "/d_lvds"}, 32'(d_lvds), 32'(exp_lv));
    check({tag, "/err"}, 32'(err), 32'(exp_err));
    check({tag, "/cal_mode"}, 32'(cal_mode), 32'd0);
    check({tag, "/busy"}, 32'(busy), 32'd0);
  endtask

  // Start a calibration and return the cycle (relative to the accepting edge) of done_o.
  // A spurious start with another mode is injected mid-search and must be ignored.
  task automatic run_cal(input logic [1:0] m, output int lat, output logic busy1);
    @(negedge clk);
    mode  = m;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    mode  = ~m;
    lat   = -1;
    busy1 = busy;
    for (int j = 1; j <= 400; j++) begin
      if (j > 1) @(negedge clk);
      if (j == 20) begin start = 1'b1; mode = MODE_LVDS ^ MODE_SG ^ m; end
      if (j == 21) start = 1'b0;
      if (done) begin
        lat = j;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic cal_and_check(input string tag, input logic [1:0] m, input int kind, input int tgt);
    int lat;
    logic busy1;
    int w;
    int code;
    cell_kind = kind;
    if (m == MODE_SG) tgt_sg = tgt; else tgt_lv = tgt;
    w    = (m == MODE_SG) ? SGB : LVB;
    code = ref_code(kind, tgt, w);
    if (m == MODE_SG) exp_sg = code; else exp_lv = code;
    exp_err = ((code == 0) || (code == (1 << w) - 1)) ? 2'b10 : 2'b00;
    run_cal(m, lat, busy1);
    check({tag, "/busy_k1"}, 32'(busy1), 32'd1);
    check({tag, "/done_lat"}, 32'(lat), 32'(1 + w * (SET + NS + 2)));
    check_stored(tag);
    @(negedge clk);
    check({tag, "/done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int lat;
    logic busy1;
    logic seen_done;
    logic [1:0] rm;

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_stored("reset");
    check("reset/done", 32'(done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_stored("post_reset");

    // Abort mid-search right after reset: mid-scale codes must survive.
    cell_kind = 0;
    tgt_sg = 10;
    @(negedge clk);
    mode = MODE_SG;
    start = 1'b1;
    @(posedge clk);
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("abort/busy_before", 32'(busy), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort/busy_k41", 32'(busy), 32'd0);
    check("abort/cal_mode", 32'(cal_mode), 32'd0);
    seen_done = done;
    for (int j = 0; j < 100; j++) begin
      @(negedge clk);
      seen_done = seen_done | done;
    end
    check("abort/no_done", 32'(seen_done), 32'd0);
    check_stored("abort");

    // Directed nominal cases
    cal_and_check("sg_nom", MODE_SG, 0, 10);
    check("sg_nom/therm_literal", 32'(d_iosg), 32'h03FF);
    cal_and_check("lv_nom", MODE_LVDS, 0, 6);
    check("lv_nom/d_lvds_literal", 32'(d_lvds), 32'h6);

    // Saturation and majority filtering
    cal_and_check("sat_hi", MODE_SG, 1, 0);
    cal_and_check("sat_lo", MODE_SG, 2, 0);
    cal_and_check("glitch", MODE_SG, 3, 0);
    cal_and_check("lv_sat", MODE_LVDS, 1, 0);

    // Randomised targets on random channels
    for (int n = 0; n < 6; n++) begin
      rm = ($urandom_range(0, 1) == 0) ? MODE_SG : MODE_LVDS;
      cal_and_check($sformatf("rand%0d", n), rm, 0, int'($urandom_range(0, 15)));
    end

    // Illegal mode: immediate done with err[0], codes untouched
    @(negedge clk);
    mode = 2'b11;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    exp_err = 2'b01;
    check("illegal/done_k1", 32'(done), 32'd1);
    check("illegal/busy", 32'(busy), 32'd0);
    check_stored("illegal");
    @(negedge clk);
    check("illegal/done_pulse", 32'(done), 32'd0);

    // Asynchronous reset mid-search
    cell_kind = 0;
    tgt_lv = 3;
    @(negedge clk);
    mode = MODE_LVDS;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    check("rst_mid/busy_before", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    exp_sg = 8;
    exp_lv = 8;
    exp_err = 2'b00;
    check_stored("rst_mid");
    check("rst_mid/done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_stored("rst_mid_after");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
